// File: rtl/llsc_reservation_ctrl_if.sv
// SC request/response handshake toward the pipeline and store handshake toward the dcache.
// The reservation controller connects through the slave modport.
interface llsc_reservation_ctrl_if #(
    parameter int PADDR_W = 32,
    parameter int DATA_W  = 32
);
    logic               sc_valid;
    logic               sc_ready;
    logic [PADDR_W-1:0] sc_paddr;
    logic [DATA_W-1:0]  sc_wdata;
    logic               sc_resp_valid;
    logic               sc_resp_success;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [PADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0]  mem_req_data;
    logic               mem_ack;

    modport slave (
        input  sc_valid, sc_paddr, sc_wdata, mem_req_ready, mem_ack,
        output sc_ready, sc_resp_valid, sc_resp_success,
               mem_req_valid, mem_req_addr, mem_req_data
    );

    modport master (
        output sc_valid, sc_paddr, sc_wdata, mem_req_ready, mem_ack,
        input  sc_ready, sc_resp_valid, sc_resp_success,
               mem_req_valid, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/llsc_reservation_ctrl.sv
// LL/SC reservation owner: holds LLbit plus reserved address, applies clear sources by
// priority, and sequences SC.W through check, dcache store handshake and result pulse.
module llsc_reservation_ctrl #(
    parameter int PADDR_W   = 32,
    parameter int DATA_W    = 32,
    parameter int GRAN_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    llsc_reservation_ctrl_if.slave bus,
    input  logic                ll_valid,
    input  logic [PADDR_W-1:0]  ll_paddr,
    input  logic                exception_flush,
    input  logic                ertn,
    input  logic                llbctl_klo,
    input  logic                llbctl_wcllb,
    output logic                klo_clr,
    input  logic                inv_valid,
    input  logic [PADDR_W-1:0]  inv_paddr,
    output logic                llbit_o,
    output logic [PADDR_W-1:0]  rsv_addr_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SC_REQ   = 3'd1,
        SC_WAIT  = 3'd2,
        SC_DRAIN = 3'd3,
        SC_RESP  = 3'd4
    } state_t;

    state_t             state, state_d;
    logic               llbit_d;
    logic [PADDR_W-1:0] rsv_d;
    logic               sc_accept;
    logic               sc_pass;
    logic [PADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0]  req_data_q;
    logic               resp_success_q;

    function automatic logic gran_match(input logic [PADDR_W-1:0] a,
                                        input logic [PADDR_W-1:0] b);
        return a[PADDR_W-1:GRAN_LOG2] == b[PADDR_W-1:GRAN_LOG2];
    endfunction

    // The SC check sees the reservation as registered before this cycle's updates.
    assign sc_pass = llbit_o && gran_match(bus.sc_paddr, rsv_addr_o);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        llbit_d = llbit_o;
        rsv_d   = rsv_addr_o;
        if (exception_flush)
            llbit_d = 1'b0;
        else if (inv_valid && llbit_o && gran_match(inv_paddr, rsv_addr_o))
            llbit_d = 1'b0;
        else if (llbctl_wcllb)
            llbit_d = 1'b0;
        else if (ertn)
            llbit_d = llbctl_klo ? llbit_o : 1'b0;
        else if (sc_accept)
            llbit_d = 1'b0;
        else if (ll_valid) begin
            llbit_d = 1'b1;
            rsv_d   = ll_paddr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_o    <= 1'b0;
            rsv_addr_o <= '0;
            klo_clr    <= 1'b0;
        end else begin
            llbit_o    <= llbit_d;
            rsv_addr_o <= rsv_d;
            klo_clr    <= ertn & llbctl_klo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     if (sc_accept) state_d = sc_pass ? SC_REQ : SC_RESP;
            // A handshake completing alongside a flush has issued the store; it must drain.
            SC_REQ: begin
                if (bus.mem_req_ready)   state_d = exception_flush ? SC_DRAIN : SC_WAIT;
                else if (exception_flush) state_d = IDLE;
            end
            SC_WAIT: begin
                if (bus.mem_ack)          state_d = SC_RESP;
                else if (exception_flush) state_d = SC_DRAIN;
            end
            SC_DRAIN: if (bus.mem_ack) state_d = IDLE;
            SC_RESP:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        sc_accept           = (state == IDLE) && bus.sc_valid && !exception_flush;
        bus.sc_ready        = sc_accept;
        bus.mem_req_valid   = (state == SC_REQ);
        bus.mem_req_addr    = req_addr_q;
        bus.mem_req_data    = req_data_q;
        bus.sc_resp_valid   = (state == SC_RESP) && !exception_flush;
        bus.sc_resp_success = (state == SC_RESP) && !exception_flush && resp_success_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr_q     <= '0;
            req_data_q     <= '0;
            resp_success_q <= 1'b0;
        end else if (sc_accept) begin
            resp_success_q <= 1'b0;
            if (sc_pass) begin
                req_addr_q <= bus.sc_paddr;
                req_data_q <= bus.sc_wdata;
            end
        end else if (state == SC_WAIT && bus.mem_ack) begin
            resp_success_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_llsc_reservation_ctrl.sv
// Directed bench for llsc_reservation_ctrl: per-cycle vector table plus hand-written
// flush sequences around the dcache store handshake.
module tb_llsc_reservation_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ll_valid, exception_flush, ertn, llbctl_klo, llbctl_wcllb, inv_valid;
    logic [31:0] ll_paddr, inv_paddr;
    logic        klo_clr, llbit_o;
    logic [31:0] rsv_addr_o;

    int checks = 0;
    int errors = 0;

    llsc_reservation_ctrl_if #(.PADDR_W(32), .DATA_W(32)) bus ();

    llsc_reservation_ctrl #(.PADDR_W(32), .DATA_W(32), .GRAN_LOG2(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .ll_valid        (ll_valid),
        .ll_paddr        (ll_paddr),
        .exception_flush (exception_flush),
        .ertn            (ertn),
        .llbctl_klo      (llbctl_klo),
        .llbctl_wcllb    (llbctl_wcllb),
        .klo_clr         (klo_clr),
        .inv_valid       (inv_valid),
        .inv_paddr       (inv_paddr),
        .llbit_o         (llbit_o),
        .rsv_addr_o      (rsv_addr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // inf = {ll, scv, rdy, ack, fl, ertn, klo, wcllb, inv}; exf = {ready, rv, rs, mv, kclr, llb}
    typedef struct {
        string       name;
        logic [8:0]  inf;
        logic [31:0] ll_pa, sc_pa, wd, inv_pa;
        logic [5:0]  exf;
        logic [31:0] e_maddr, e_mdata, e_rsv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [8:0] inf,
                                input logic [31:0] ll_pa, input logic [31:0] sc_pa,
                                input logic [31:0] wd, input logic [31:0] inv_pa,
                                input logic [5:0] exf, input logic [31:0] e_maddr,
                                input logic [31:0] e_mdata, input logic [31:0] e_rsv);
        vec_t v;
        v.name = name; v.inf = inf; v.ll_pa = ll_pa; v.sc_pa = sc_pa; v.wd = wd;
        v.inv_pa = inv_pa; v.exf = exf; v.e_maddr = e_maddr; v.e_mdata = e_mdata; v.e_rsv = e_rsv;
        return v;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp_v);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic idle_inputs();
        ll_valid = 0; ll_paddr = '0; exception_flush = 0; ertn = 0; llbctl_klo = 0;
        llbctl_wcllb = 0; inv_valid = 0; inv_paddr = '0;
        bus.sc_valid = 0; bus.sc_paddr = '0; bus.sc_wdata = '0;
        bus.mem_req_ready = 0; bus.mem_ack = 0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        {ll_valid, bus.sc_valid, bus.mem_req_ready, bus.mem_ack, exception_flush,
         ertn, llbctl_klo, llbctl_wcllb, inv_valid} = v.inf;
        ll_paddr = v.ll_pa; bus.sc_paddr = v.sc_pa; bus.sc_wdata = v.wd; inv_paddr = v.inv_pa;
        #2;
        check1({v.name, ".sc_ready"}, bus.sc_ready, v.exf[5]);
        check1({v.name, ".resp_valid"}, bus.sc_resp_valid, v.exf[4]);
        check1({v.name, ".resp_success"}, bus.sc_resp_success, v.exf[3]);
        check1({v.name, ".mem_req_valid"}, bus.mem_req_valid, v.exf[2]);
        check1({v.name, ".klo_clr"}, klo_clr, v.exf[1]);
        check1({v.name, ".llbit"}, llbit_o, v.exf[0]);
        check32({v.name, ".rsv_addr"}, rsv_addr_o, v.e_rsv);
        if (v.exf[2]) begin
            check32({v.name, ".mem_req_addr"}, bus.mem_req_addr, v.e_maddr);
            check32({v.name, ".mem_req_data"}, bus.mem_req_data, v.e_mdata);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        //            name        {ll,scv,rdy,ack,fl,ertn,klo,wcl,inv} ll_pa  sc_pa  wdata  inv_pa  {rdy,rv,rs,mv,kc,llb} maddr  mdata  rsv
        vecs.push_back(mk("s1_ll",    9'b1_0_0_0_0_0_0_0_0, 32'h1000_0040, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h0));
        vecs.push_back(mk("s1_sc",    9'b0_1_1_0_0_0_0_0_0, 0, 32'h1000_0048, 32'hDEAD_BEEF, 0, 6'b1_0_0_0_0_1, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s1_req",   9'b0_0_1_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_1_0_0, 32'h1000_0048, 32'hDEAD_BEEF, 32'h1000_0040));
        vecs.push_back(mk("s1_ack",   9'b0_0_1_1_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s1_resp",  9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_1_1_0_0_0, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s1_idle",  9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s2_sc",    9'b0_1_0_0_0_0_0_0_0, 0, 32'h3000_0000, 32'h0000_1234, 0, 6'b1_0_0_0_0_0, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s2_resp",  9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_1_0_0_0_0, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s2_idle",  9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s3_ll",    9'b1_0_0_0_0_0_0_0_0, 32'h2000_0000, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h1000_0040));
        vecs.push_back(mk("s3_inv_in",9'b0_0_0_0_0_0_0_0_1, 0, 0, 0, 32'h2000_000C, 6'b0_0_0_0_0_1, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s3_sc_f",  9'b0_1_0_0_0_0_0_0_0, 0, 32'h2000_0000, 32'h0000_AAAA, 0, 6'b1_0_0_0_0_0, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s3_rsp_f", 9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_1_0_0_0_0, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s3_ll2",   9'b1_0_0_0_0_0_0_0_0, 32'h2000_0000, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s3_inv_out",9'b0_0_0_0_0_0_0_0_1, 0, 0, 0, 32'h2000_0010, 6'b0_0_0_0_0_1, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s3_sc_p",  9'b0_1_1_0_0_0_0_0_0, 0, 32'h2000_0000, 32'h5555_5555, 0, 6'b1_0_0_0_0_1, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s3_req",   9'b0_0_1_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_1_0_0, 32'h2000_0000, 32'h5555_5555, 32'h2000_0000));
        vecs.push_back(mk("s3_ack",   9'b0_0_1_1_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s3_rsp_p", 9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_1_1_0_0_0, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s4_ll",    9'b1_0_0_0_0_0_0_0_0, 32'h3000_0100, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h2000_0000));
        vecs.push_back(mk("s4_ertn_k",9'b0_0_0_0_0_1_1_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_1, 0, 0, 32'h3000_0100));
        vecs.push_back(mk("s4_kclr",  9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_1_1, 0, 0, 32'h3000_0100));
        vecs.push_back(mk("s4_kclr_0",9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_1, 0, 0, 32'h3000_0100));
        vecs.push_back(mk("s4_ertn",  9'b0_0_0_0_0_1_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_1, 0, 0, 32'h3000_0100));
        vecs.push_back(mk("s4_clr",   9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h3000_0100));
        vecs.push_back(mk("s5_ll",    9'b1_0_0_0_0_0_0_0_0, 32'h4000_0000, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h3000_0100));
        vecs.push_back(mk("s5_ll_fl", 9'b1_0_0_0_1_0_0_0_0, 32'h5000_0000, 0, 0, 0, 6'b0_0_0_0_0_1, 0, 0, 32'h4000_0000));
        vecs.push_back(mk("s5_after", 9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h4000_0000));
        vecs.push_back(mk("s5_ll2",   9'b1_0_0_0_0_0_0_0_0, 32'h4000_0040, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h4000_0000));
        vecs.push_back(mk("s5_wcllb", 9'b0_0_0_0_0_0_0_1_0, 0, 0, 0, 0, 6'b0_0_0_0_0_1, 0, 0, 32'h4000_0040));
        vecs.push_back(mk("s5_wc_clr",9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h4000_0040));
        vecs.push_back(mk("s5_sc_fl", 9'b0_1_0_0_1_0_0_0_0, 0, 32'h4000_0040, 32'h1, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h4000_0040));
        vecs.push_back(mk("s5_no_acc",9'b0_0_0_0_0_0_0_0_0, 0, 0, 0, 0, 6'b0_0_0_0_0_0, 0, 0, 32'h4000_0040));

        // Reset state, sampled both during and after reset.
        #12;
        check1("rst.llbit", llbit_o, 1'b0);
        check32("rst.rsv_addr", rsv_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check1("rst.mem_req_valid", bus.mem_req_valid, 1'b0);
        check1("rst.resp_valid", bus.sc_resp_valid, 1'b0);
        check1("rst.klo_clr", klo_clr, 1'b0);
        check32("rst.mem_req_addr", bus.mem_req_addr, 32'h0);
        check32("rst.mem_req_data", bus.mem_req_data, 32'h0);

        foreach (vecs[i]) apply(vecs[i]);

        // Flush while mem_req_ready is held low: request dropped, no response.
        @(negedge clk); idle_inputs(); ll_valid = 1; ll_paddr = 32'h6000_0000;
        @(negedge clk); idle_inputs();
        bus.sc_valid = 1; bus.sc_paddr = 32'h6000_0004; bus.sc_wdata = 32'hCAFE_F00D;
        #2 check1("fa.accept", bus.sc_ready, 1'b1);
        @(negedge clk); idle_inputs();
        #2 check1("fa.req_c1", bus.mem_req_valid, 1'b1);
        check32("fa.req_addr", bus.mem_req_addr, 32'h6000_0004);
        check32("fa.req_data", bus.mem_req_data, 32'hCAFE_F00D);
        @(negedge clk); exception_flush = 1;
        #2 check1("fa.req_c2", bus.mem_req_valid, 1'b1);
        @(negedge clk); idle_inputs();
        #2 check1("fa.req_dropped", bus.mem_req_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check1("fa.no_resp", bus.sc_resp_valid, 1'b0);
        end

        // Flush in SC_WAIT, ack two cycles later: drain silently, then accept the next SC.
        @(negedge clk); idle_inputs(); ll_valid = 1; ll_paddr = 32'h7000_0000;
        @(negedge clk); idle_inputs();
        bus.sc_valid = 1; bus.sc_paddr = 32'h7000_0008; bus.sc_wdata = 32'h0BAD_CAFE;
        #2 check1("fb.accept", bus.sc_ready, 1'b1);
        @(negedge clk); idle_inputs(); bus.mem_req_ready = 1;
        #2 check1("fb.req", bus.mem_req_valid, 1'b1);
        @(negedge clk); idle_inputs(); exception_flush = 1;
        #2 check1("fb.wait_no_req", bus.mem_req_valid, 1'b0);
        @(negedge clk); idle_inputs(); bus.sc_valid = 1; bus.sc_paddr = 32'h7000_0008;
        #2 check1("fb.drain_not_ready", bus.sc_ready, 1'b0);
        check1("fb.drain_no_resp", bus.sc_resp_valid, 1'b0);
        @(negedge clk); idle_inputs(); bus.mem_ack = 1;
        #2 check1("fb.ack_no_resp", bus.sc_resp_valid, 1'b0);
        @(negedge clk); idle_inputs(); bus.sc_valid = 1; bus.sc_paddr = 32'h7000_0008;
        #2 check1("fb.next_accept", bus.sc_ready, 1'b1);
        check1("fb.idle_no_resp", bus.sc_resp_valid, 1'b0);
        @(negedge clk); idle_inputs();
        #2 check1("fb.next_resp", bus.sc_resp_valid, 1'b1);
        check1("fb.next_fail", bus.sc_resp_success, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
